// File: rtl/c17_pkg.sv
// Shared constants, net bundle type and fault-override helper for the c17 benchmark.
package c17_pkg;

    localparam int unsigned NUM_NETS = 6;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned TYPE_W   = 2;

    typedef enum logic [TYPE_W-1:0] {
        FT_SA0    = 2'b00,
        FT_SA1    = 2'b01,
        FT_INV    = 2'b10,
        FT_BRIDGE = 2'b11
    } fault_type_e;

    localparam logic [SEL_W-1:0] SEL_NONE = 3'd0;
    localparam logic [SEL_W-1:0] SEL_G1   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_G2   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_G3   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_G4   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_Z1   = 3'd5;
    localparam logic [SEL_W-1:0] SEL_Z2   = 3'd6;

    typedef struct packed {
        logic g1;
        logic g2;
        logic g3;
        logic g4;
        logic z1;
        logic z2;
    } c17_nets_t;

    // Replace a net value; a bridge takes the (already faulted) g1 value.
    function automatic logic apply_fault(input logic raw,
                                         input logic [TYPE_W-1:0] ftype,
                                         input logic bridge_val);
        logic res;
        res = raw;
        case (fault_type_e'(ftype))
            FT_SA0:    res = 1'b0;
            FT_SA1:    res = 1'b1;
            FT_INV:    res = ~raw;
            FT_BRIDGE: res = bridge_val;
            default:   res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/c17_core.sv
// Six-NAND c17 netlist with a per-net fault override applied before fan-out.
module c17_core
    import c17_pkg::*;
(
    input  logic                i_x1,
    input  logic                i_x2,
    input  logic                i_x3,
    input  logic                i_x6,
    input  logic                i_x7,
    input  logic [NUM_NETS-1:0] i_ovr_en,
    input  logic [TYPE_W-1:0]   i_fault_type,
    output c17_nets_t           o_nets
);

    logic w_g1_raw, w_g2_raw, w_g3_raw, w_g4_raw, w_z1_raw, w_z2_raw;
    logic w_g1, w_g2, w_g3, w_g4, w_z1, w_z2;

    // Bridge on g1 resolves to its own raw value, i.e. no change.
    assign w_g1_raw = ~(i_x1 & i_x3);
    assign w_g1     = i_ovr_en[0] ? apply_fault(w_g1_raw, i_fault_type, w_g1_raw) : w_g1_raw;

    assign w_g2_raw = ~(i_x3 & i_x6);
    assign w_g2     = i_ovr_en[1] ? apply_fault(w_g2_raw, i_fault_type, w_g1) : w_g2_raw;

    assign w_g3_raw = ~(i_x2 & w_g2);
    assign w_g3     = i_ovr_en[2] ? apply_fault(w_g3_raw, i_fault_type, w_g1) : w_g3_raw;

    assign w_g4_raw = ~(w_g2 & i_x7);
    assign w_g4     = i_ovr_en[3] ? apply_fault(w_g4_raw, i_fault_type, w_g1) : w_g4_raw;

    assign w_z1_raw = ~(w_g1 & w_g3);
    assign w_z1     = i_ovr_en[4] ? apply_fault(w_z1_raw, i_fault_type, w_g1) : w_z1_raw;

    assign w_z2_raw = ~(w_g3 & w_g4);
    assign w_z2     = i_ovr_en[5] ? apply_fault(w_z2_raw, i_fault_type, w_g1) : w_z2_raw;

    assign o_nets = '{g1: w_g1, g2: w_g2, g3: w_g3, g4: w_g4, z1: w_z1, z2: w_z2};

endmodule

// File: rtl/c17.sv
// c17 benchmark with fault injection, golden reference, majority vote and error flags.
module c17
    import c17_pkg::*;
#(
    parameter int unsigned FAULT_INJECT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x1,
    input  logic              x2,
    input  logic              x3,
    input  logic              x6,
    input  logic              x7,
    input  logic              fault_en,
    input  logic [SEL_W-1:0]  fault_sel,
    input  logic [TYPE_W-1:0] fault_type,
    output logic              z1,
    output logic              z2,
    output logic              vote,
    output logic              mismatch,
    output logic              err_sticky
);

    logic [NUM_NETS-1:0] w_ovr_en;
    c17_nets_t           w_faulty;
    c17_nets_t           w_gold;
    logic                w_mismatch;
    logic                w_vote;

    logic g1, g2, g3, g4;

    logic r_z1, r_z2, r_vote, r_mismatch, r_err_sticky;

    // One-hot override decode; selects 0 and 7 match no net.
    always_comb begin
        w_ovr_en = '0;
        for (int i = 0; i < int'(NUM_NETS); i++) begin
            w_ovr_en[i] = (FAULT_INJECT != 0) && fault_en && (fault_sel == SEL_W'(i + 1));
        end
    end

    c17_core u_faulty (
        .i_x1         (x1),
        .i_x2         (x2),
        .i_x3         (x3),
        .i_x6         (x6),
        .i_x7         (x7),
        .i_ovr_en     (w_ovr_en),
        .i_fault_type (fault_type),
        .o_nets       (w_faulty)
    );

    c17_core u_golden (
        .i_x1         (x1),
        .i_x2         (x2),
        .i_x3         (x3),
        .i_x6         (x6),
        .i_x7         (x7),
        .i_ovr_en     ('0),
        .i_fault_type (fault_type),
        .o_nets       (w_gold)
    );

    assign g1 = w_faulty.g1;
    assign g2 = w_faulty.g2;
    assign g3 = w_faulty.g3;
    assign g4 = w_faulty.g4;

    // Probe-only nets; folded here so they remain visible after elaboration.
    logic w_unused_probe;
    assign w_unused_probe = ^{g1, g2, g3, g4, w_gold.g1, w_gold.g2, w_gold.g3, w_gold.g4};

    assign w_mismatch = (w_faulty.z1 != w_gold.z1) | (w_faulty.z2 != w_gold.z2);
    assign w_vote     = (w_faulty.z1 & w_faulty.z2) | (w_faulty.z1 & x7) | (w_faulty.z2 & x7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z1         <= 1'b0;
            r_z2         <= 1'b0;
            r_vote       <= 1'b0;
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_z1         <= w_faulty.z1;
            r_z2         <= w_faulty.z2;
            r_vote       <= w_vote;
            r_mismatch   <= w_mismatch;
            r_err_sticky <= r_err_sticky | w_mismatch;
        end
    end

    assign z1         = r_z1;
    assign z2         = r_z2;
    assign vote       = r_vote;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_c17.sv
// Self-checking bench for c17: directed vector table, random model-driven vectors, reset corner.
module tb_c17;

    logic       clk;
    logic       rst_n;
    logic       x1, x2, x3, x6, x7;
    logic       fault_en;
    logic [2:0] fault_sel;
    logic [1:0] fault_type;
    logic       z1, z2, vote, mismatch, err_sticky;

    c17 #(.FAULT_INJECT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x6         (x6),
        .x7         (x7),
        .fault_en   (fault_en),
        .fault_sel  (fault_sel),
        .fault_type (fault_type),
        .z1         (z1),
        .z2         (z2),
        .vote       (vote),
        .mismatch   (mismatch),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] x;      // {x1,x2,x3,x6,x7}
        logic       fen;
        logic [2:0] sel;
        logic [1:0] ft;
        logic       z1;
        logic       z2;
        logic       vote;
        logic       mm;
    } vec_t;

    typedef struct {
        logic z1;
        logic z2;
        logic vote;
        logic mm;
        logic st;
        int   id;
    } exp_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];
    exp_t sbq [$];
    int   n_cmp;
    int   n_err;
    logic sb_sticky;

    task automatic check(input string name, input int id, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s id=%0d got=%b want=%b", name, id, act, exp);
        end
    endtask

    // Independent reference: nets indexed 1..6, fault applied as each net is formed.
    function automatic logic [1:0] model(input logic [4:0] x, input logic fen,
                                         input logic [2:0] sel, input logic [1:0] ft);
        logic [6:1] n;
        logic a, b, c, d, e;
        {a, b, c, d, e} = x;
        n = '0;
        for (int k = 1; k <= 6; k++) begin
            case (k)
                1: n[k] = ~(a & c);
                2: n[k] = ~(c & d);
                3: n[k] = ~(b & n[2]);
                4: n[k] = ~(n[2] & e);
                5: n[k] = ~(n[1] & n[3]);
                default: n[k] = ~(n[3] & n[4]);
            endcase
            if (fen && sel == 3'(k)) begin
                case (ft)
                    2'b00: n[k] = 1'b0;
                    2'b01: n[k] = 1'b1;
                    2'b10: n[k] = ~n[k];
                    default: n[k] = n[1];
                endcase
            end
        end
        return {n[5], n[6]};
    endfunction

    task automatic drive(input logic [4:0] x, input logic fen, input logic [2:0] sel,
                         input logic [1:0] ft, input logic ez1, input logic ez2,
                         input logic evote, input logic emm, input int id);
        exp_t e;
        {x1, x2, x3, x6, x7} = x;
        fault_en   = fen;
        fault_sel  = sel;
        fault_type = ft;
        sb_sticky  = sb_sticky | emm;
        e.z1 = ez1; e.z2 = ez2; e.vote = evote; e.mm = emm; e.st = sb_sticky; e.id = id;
        sbq.push_back(e);
    endtask

    task automatic check_pending();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("z1", e.id, z1, e.z1);
            check("z2", e.id, z2, e.z2);
            check("vote", e.id, vote, e.vote);
            check("mismatch", e.id, mismatch, e.mm);
            check("err_sticky", e.id, err_sticky, e.st);
        end
    endtask

    initial begin
        logic [4:0] rx;
        logic       rfen;
        logic [2:0] rsel;
        logic [1:0] rft;
        logic [1:0] fz;
        logic [1:0] gz;

        n_cmp = 0;
        n_err = 0;
        sb_sticky = 1'b0;

        //            x(x1..x7) fen sel  ft    z1 z2 vote mm
        tbl[0]  = '{5'b00000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{5'b10110, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{5'b11101, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{5'b10101, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{5'b00000, 1'b1, 3'd7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{5'b00000, 1'b1, 3'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{5'b00000, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{5'b00000, 1'b1, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{5'b00000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{5'b11101, 1'b1, 3'd1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{5'b00000, 1'b1, 3'd6, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{5'b10110, 1'b1, 3'd3, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{5'b10101, 1'b1, 3'd4, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        {x1, x2, x3, x6, x7} = 5'b00000;
        fault_en = 1'b0; fault_sel = 3'd0; fault_type = 2'd0;

        #3;
        check("rst_z1", -1, z1, 1'b0);
        check("rst_z2", -1, z2, 1'b0);
        check("rst_vote", -1, vote, 1'b0);
        check("rst_mismatch", -1, mismatch, 1'b0);
        check("rst_err_sticky", -1, err_sticky, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            check_pending();
            drive(tbl[i].x, tbl[i].fen, tbl[i].sel, tbl[i].ft,
                  tbl[i].z1, tbl[i].z2, tbl[i].vote, tbl[i].mm, i);
        end

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_pending();
            rx   = 5'($urandom_range(0, 31));
            rfen = 1'($urandom_range(0, 1));
            rsel = 3'($urandom_range(0, 7));
            rft  = 2'($urandom_range(0, 3));
            fz   = model(rx, rfen, rsel, rft);
            gz   = model(rx, 1'b0, 3'd0, 2'd0);
            drive(rx, rfen, rsel, rft, fz[1], fz[0],
                  (fz[1] & fz[0]) | (fz[1] & rx[0]) | (fz[0] & rx[0]),
                  fz != gz, 100 + i);
        end

        @(negedge clk);
        check_pending();
        check("sticky_before_reset", 200, err_sticky, 1'b1);

        // Asynchronous reset pulse between edges while the sticky flag is set.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_z1", 201, z1, 1'b0);
        check("async_rst_z2", 201, z2, 1'b0);
        check("async_rst_vote", 201, vote, 1'b0);
        check("async_rst_mismatch", 201, mismatch, 1'b0);
        check("async_rst_err_sticky", 201, err_sticky, 1'b0);
        sb_sticky = 1'b0;
        sbq.delete();

        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b11101, 1'b0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 202);
        @(negedge clk);
        check_pending();
        drive(5'b10110, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 203);
        @(negedge clk);
        check_pending();
        check("queue_drained", 204, 1'(sbq.size() == 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
